// File: rtl/keypad_arbiter.sv
// rtl/keypad_arbiter.sv - round-robin keypad session arbiter for the security FSM entry port
module keypad_arbiter #(
  parameter int NUM_PADS    = 2,
  parameter int TIMEOUT     = 1000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 10000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*NUM_PADS-1:0]         pad_command,
  input  logic [4*NUM_PADS-1:0]         pad_digit,
  input  logic [NUM_PADS-1:0]           pad_digit_valid,
  input  logic                          sys_armed,
  output logic [1:0]                    command,
  output logic [3:0]                    digit,
  output logic                          digit_enterd,
  output logic [NUM_PADS-1:0]           grant,
  output logic                          busy,
  output logic                          locked,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

  localparam int PW = $clog2(NUM_PADS);
  localparam int TW = $clog2(TIMEOUT);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    CMD_ARM    = 2'd1;
  localparam logic [1:0]    CMD_DISARM = 2'd2;
  localparam logic [3:0]    FILL_DIGIT = 4'hF;

  typedef enum logic [2:0] {IDLE, CMD, COLLECT, FILL, WAIT, CHECK, LOCKOUT} state_t;

  state_t        state, nxt_state;
  logic [PW-1:0] last_grant, nxt_last_grant;
  logic [1:0]    cmd_lat, nxt_cmd_lat;
  logic [1:0]    dcnt, nxt_dcnt;
  logic [TW-1:0] timer, nxt_timer;
  logic [LW-1:0] lcnt, nxt_lcnt;

  logic [1:0]          nxt_command;
  logic [3:0]          nxt_digit;
  logic                nxt_digit_enterd;
  logic [NUM_PADS-1:0] nxt_grant;
  logic                nxt_busy;
  logic                nxt_locked;
  logic [FW-1:0]       nxt_fail_count;
  logic [FW-1:0]       fail_inc;

  logic          req_found;
  logic [PW-1:0] win_idx;
  logic [1:0]    win_cmd;
  logic [1:0]    cand_cmd;
  int            scan_idx;

  logic       sel_valid;
  logic [3:0] sel_digit;

  // The session owner's strobe and digit; other pads never reach the datapath.
  assign sel_valid = pad_digit_valid[last_grant];
  assign sel_digit = pad_digit[4*int'(last_grant) +: 4];
  assign fail_inc  = fail_count + FW'(1);

  // Round-robin pick: scan pads starting just after the previous owner.
  always_comb begin
    req_found = 1'b0;
    win_idx   = '0;
    win_cmd   = 2'd0;
    scan_idx  = 0;
    cand_cmd  = 2'd0;
    for (int off = 1; off <= NUM_PADS; off++) begin
      scan_idx = (int'(last_grant) + off) % NUM_PADS;
      cand_cmd = pad_command[2*scan_idx +: 2];
      if (!req_found && (cand_cmd == CMD_ARM || cand_cmd == CMD_DISARM)) begin
        req_found = 1'b1;
        win_idx   = PW'(scan_idx);
        win_cmd   = cand_cmd;
      end
    end
  end

  // Session sequencing: next state plus next value of every registered output.
  always_comb begin
    nxt_state        = state;
    nxt_last_grant   = last_grant;
    nxt_cmd_lat      = cmd_lat;
    nxt_dcnt         = dcnt;
    nxt_timer        = timer;
    nxt_lcnt         = lcnt;
    nxt_command      = 2'd0;
    nxt_digit        = digit;
    nxt_digit_enterd = 1'b0;
    nxt_grant        = grant;
    nxt_busy         = busy;
    nxt_locked       = locked;
    nxt_fail_count   = fail_count;
    case (state)
      IDLE: begin
        if (req_found) begin
          nxt_state      = CMD;
          nxt_last_grant = win_idx;
          nxt_cmd_lat    = win_cmd;
          nxt_command    = win_cmd;
          nxt_grant      = NUM_PADS'(1) << win_idx;
          nxt_busy       = 1'b1;
        end
      end
      CMD: begin
        nxt_dcnt  = 2'd0;
        nxt_timer = '0;
        nxt_state = COLLECT;
      end
      COLLECT: begin
        // A strobe on the last timer cycle is still accepted ahead of the timeout.
        if (dcnt == 2'd3) begin
          nxt_state = WAIT;
        end else if (sel_valid) begin
          nxt_digit        = sel_digit;
          nxt_digit_enterd = 1'b1;
          nxt_dcnt         = dcnt + 2'd1;
          nxt_timer        = '0;
        end else if (timer == TMO_LAST) begin
          nxt_digit        = FILL_DIGIT;
          nxt_digit_enterd = 1'b1;
          nxt_dcnt         = dcnt + 2'd1;
          nxt_state        = FILL;
        end else begin
          nxt_timer = timer + TW'(1);
        end
      end
      FILL: begin
        if (dcnt == 2'd3) begin
          nxt_state = WAIT;
        end else begin
          nxt_digit        = FILL_DIGIT;
          nxt_digit_enterd = 1'b1;
          nxt_dcnt         = dcnt + 2'd1;
        end
      end
      WAIT: begin
        nxt_state = CHECK;
      end
      CHECK: begin
        nxt_grant = '0;
        nxt_busy  = 1'b0;
        nxt_state = IDLE;
        if (cmd_lat == CMD_DISARM) begin
          if (sys_armed) begin
            nxt_fail_count = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              nxt_state  = LOCKOUT;
              nxt_locked = 1'b1;
              nxt_lcnt   = '0;
            end
          end else begin
            nxt_fail_count = '0;
          end
        end
      end
      LOCKOUT: begin
        if (lcnt == LOCK_LAST) begin
          nxt_locked     = 1'b0;
          nxt_fail_count = '0;
          nxt_state      = IDLE;
        end else begin
          nxt_lcnt = lcnt + LW'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State and all registered outputs advance together; reset clears them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= PW'(NUM_PADS - 1);
      cmd_lat      <= 2'd0;
      dcnt         <= 2'd0;
      timer        <= '0;
      lcnt         <= '0;
      command      <= 2'd0;
      digit        <= 4'd0;
      digit_enterd <= 1'b0;
      grant        <= '0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      fail_count   <= '0;
    end else begin
      state        <= nxt_state;
      last_grant   <= nxt_last_grant;
      cmd_lat      <= nxt_cmd_lat;
      dcnt         <= nxt_dcnt;
      timer        <= nxt_timer;
      lcnt         <= nxt_lcnt;
      command      <= nxt_command;
      digit        <= nxt_digit;
      digit_enterd <= nxt_digit_enterd;
      grant        <= nxt_grant;
      busy         <= nxt_busy;
      locked       <= nxt_locked;
      fail_count   <= nxt_fail_count;
    end
  end

endmodule

// File: doc/keypad_arbiter.md
# keypad_arbiter

Shares the home-security FSM's single command/digit entry port between `NUM_PADS` independent keypads. Grants one keypad an exclusive session per arm/disarm attempt, forwards that keypad's command and three code digits, fills abandoned sessions with invalid digits so the FSM never stalls mid-sequence, and locks out all keypads after `MAX_FAIL` consecutive failed disarm attempts. It sits between the keypad front-ends and the security FSM's `command`/`digit`/`digit_enterd` inputs, and observes the FSM's `armed` output.

## Interface
- `NUM_PADS`, 2: number of keypads; legal range 2..4.
- `TIMEOUT`, 1000: idle cycles allowed between digits in a session; must be ≥ 2.
- `MAX_FAIL`, 3: consecutive failed disarms that trigger lockout; must be ≥ 1.
- `LOCK_CYCLES`, 10000: lockout duration in cycles; must be ≥ 1.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset; 0 clears all state immediately.
- `pad_command` in 2*NUM_PADS: per-pad command; pad i occupies bits [2i+1:2i]. 0 = none, 1 = arm, 2 = disarm, 3 = ignored.
- `pad_digit` in 4*NUM_PADS: per-pad digit; pad i occupies bits [4i+3:4i].
- `pad_digit_valid` in NUM_PADS: per-pad single-cycle digit strobe.
- `sys_armed` in 1: `armed` output of the security FSM.
- `command` out 2: command to the FSM.
- `digit` out 4: digit to the FSM.
- `digit_enterd` out 1: digit strobe to the FSM.
- `grant` out NUM_PADS: one-hot owner of the current session; 0 when no session is open.
- `busy` out 1: session in progress.
- `locked` out 1: lockout active.
- `fail_count` out $clog2(MAX_FAIL+1): consecutive failed disarm count.

## Operation
- States: IDLE, CMD, COLLECT, FILL, WAIT, CHECK, LOCKOUT. All outputs are registered.
- IDLE: a pad requests when its command is 1 or 2. Winner is chosen round-robin: the search starts at `last_grant+1`, and after reset pad 0 has top priority.
  - On a request, latch the command and the one-hot grant, then go to CMD.
  - Digit strobes are ignored in IDLE.
- CMD: `command` equals the latched value for exactly this one cycle. Clear `dcnt` and `timer`. Go to COLLECT.
- COLLECT: only the granted pad's inputs are used; other pads are ignored entirely.
  - When the granted pad's valid is 1, register the digit, pulse `digit_enterd`, increment `dcnt` and clear `timer`.
  - When `dcnt` reaches 3, go to WAIT.
  - When no valid arrives, `timer` increments. At `timer == TIMEOUT-1` with no valid, go to FILL. A valid in that same cycle wins over the timeout.
- FILL: emit `digit = 4'hF` with `digit_enterd = 1` once per cycle until `dcnt == 3`, then go to WAIT.
- WAIT: one cycle, so the FSM consumes the last digit. Go to CHECK.
- CHECK: samples `sys_armed`.
  - Disarm session with `sys_armed == 0`: clear `fail_count` and go to IDLE.
  - Disarm session with `sys_armed == 1`: increment `fail_count`. If it reaches `MAX_FAIL`, go to LOCKOUT; otherwise go to IDLE.
  - Arm session: `fail_count` is unchanged; go to IDLE.
  - Disarm sessions completed through FILL count as failures.
- LOCKOUT: `locked = 1` and every pad input is ignored. After LOCK_CYCLES cycles, clear `fail_count` and go to IDLE.
- Commands arriving outside IDLE are dropped, not queued.
- `busy = 1` in CMD, COLLECT, FILL, WAIT and CHECK. `grant` is held through the same states.
- `last_grant` updates on entry to CMD.

## Timing
- Reset values: `command = 0`, `digit = 0`, `digit_enterd = 0`, `grant = 0`, `busy = 0`, `locked = 0`, `fail_count = 0`. State resets to IDLE and the round-robin pointer selects pad 0.
- Request in IDLE at cycle 0:
  - cycle 1: `command` and `grant` visible, `busy = 1`.
  - cycle 2: COLLECT begins.
- Digit latency: a pad strobe in cycle k produces `digit`/`digit_enterd` in cycle k+1.
- `digit_enterd` is never high for two sessions' digits back-to-back without a CMD cycle between them.
- Third digit out in cycle t: WAIT in cycle t+1, CHECK in cycle t+2, `sys_armed` sampled at the end of t+2, IDLE or LOCKOUT in cycle t+3.
- Timeout: FILL digits start `TIMEOUT` cycles after the last accepted digit (or after COLLECT entry) and come out in consecutive cycles.
- Lockout: `locked` is high for exactly LOCK_CYCLES cycles.
- Reset mid-session: asynchronous. All outputs drop to reset values immediately, and no FILL is issued.

## Test plan
- Pad 0 sends arm (1), then digits 1, 2, 4 → `command = 1` for one cycle, three `digit_enterd` pulses each one cycle after its strobe, `grant = 01` through CHECK, `fail_count` stays 0.
- Pads 0 and 1 request in the same cycle, twice in a row → pad 0 wins first, pad 1 wins the second session; pad 1's digits during pad 0's session are not forwarded.
- Disarm with digits 1, 2, 3 and `sys_armed = 1` → `fail_count = 1`. Repeat to 3 → `locked = 1` for LOCK_CYCLES cycles, pad commands ignored, then `fail_count = 0`.
- Disarm, one digit, then silence with `TIMEOUT = 8` → two `4'hF` digits in consecutive cycles 8 cycles after the digit; counts as a failure.
- Valid strobe in exactly the timeout cycle → the digit is forwarded and no FILL occurs.
- `reset` pulled low during COLLECT → all outputs are 0 immediately; the next request is granted to pad 0.
